// File: rtl/filtro_scheduler_pkg.sv
// Shared constants for the two-channel filter scheduler:
// default sample width, default tap count, FSM state encodings.
package filtro_scheduler_pkg;

  localparam int ancho      = 12;
  localparam int N_TAPS_DEF = 5;
  localparam int TAP_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } fsm_t;

endpackage

// File: rtl/filtro_canal_captura.sv
// Per-channel capture: sample buffer, pending bit, sticky overrun
// flag and (with FILTRO_OVERRUN_CNT_EN) a saturating 8-bit counter.
// Ports: clk, reset (async, active-low), i_tick/i_uk (sample strobe),
// i_clr (served by scheduler), o_buf, o_pend, o_ovr, [o_ovr_cnt].
module filtro_canal_captura
  import filtro_scheduler_pkg::*;
#(
  parameter int ANCHO = ancho
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic [ANCHO-1:0] i_uk,
  input  logic             i_clr,
  output logic [ANCHO-1:0] o_buf,
  output logic             o_pend,
  output logic             o_ovr
`ifdef FILTRO_OVERRUN_CNT_EN
  ,
  output logic [7:0]       o_ovr_cnt
`endif
);

  logic [ANCHO-1:0] r_buf;
  logic             r_pend;
  logic             r_ovr;
  logic             w_ovr_evt;

  // A tick landing on the clear cycle is a fresh sample, not a loss.
  assign w_ovr_evt = i_tick & r_pend & ~i_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf  <= '0;
      r_pend <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (i_tick) begin
        r_buf  <= i_uk;
        r_pend <= 1'b1;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end
      if (w_ovr_evt) r_ovr <= 1'b1;
    end
  end

`ifdef FILTRO_OVERRUN_CNT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_ovr_evt && r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_ovr_cnt = r_cnt;
`endif

  assign o_buf  = r_buf;
  assign o_pend = r_pend;
  assign o_ovr  = r_ovr;

endmodule

// File: rtl/filtro_scheduler.sv
// Round-robin scheduler sharing one MAC filter datapath between
// channels A and B: IDLE->LOAD->MAC(N_TAPS)->SHIFT->DONE.
// Ports: clk, reset (async, active-low), rx_done_tick_a/b, uk_a/b in;
// mac_uk, ch_sel, tap_sel, acc_clr, acc_en, hist_shift, listo,
// ch_done, overrun_a/b out; ovr_cnt_a/b with FILTRO_OVERRUN_CNT_EN.
module filtro_scheduler
  import filtro_scheduler_pkg::*;
#(
  parameter int ANCHO  = ancho,
  parameter int N_TAPS = N_TAPS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_done_tick_a,
  input  logic             rx_done_tick_b,
  input  logic [ANCHO-1:0] uk_a,
  input  logic [ANCHO-1:0] uk_b,
  output logic [ANCHO-1:0] mac_uk,
  output logic             ch_sel,
  output logic [2:0]       tap_sel,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             hist_shift,
  output logic             listo,
  output logic             ch_done,
  output logic             overrun_a,
  output logic             overrun_b
`ifdef FILTRO_OVERRUN_CNT_EN
  ,
  output logic [7:0]       ovr_cnt_a,
  output logic [7:0]       ovr_cnt_b
`endif
);

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);

  fsm_t             r_state;
  fsm_t             w_next;
  logic             w_load;
  logic             w_pick;
  logic [ANCHO-1:0] w_buf_a;
  logic [ANCHO-1:0] w_buf_b;
  logic             w_pend_a;
  logic             w_pend_b;
  logic             w_clr_a;
  logic             w_clr_b;

  logic [ANCHO-1:0] r_mac_uk;
  logic             r_ch_sel;
  logic [2:0]       r_tap;
  logic             r_acc_clr;
  logic             r_acc_en;
  logic             r_hist;
  logic             r_listo;
  logic             r_ch_done;
  logic             r_prio;

  assign w_clr_a = (r_state == ST_DONE) & ~r_ch_sel;
  assign w_clr_b = (r_state == ST_DONE) &  r_ch_sel;

  filtro_canal_captura #(.ANCHO(ANCHO)) u_cap_a (
    .clk       (clk),
    .reset     (reset),
    .i_tick    (rx_done_tick_a),
    .i_uk      (uk_a),
    .i_clr     (w_clr_a),
    .o_buf     (w_buf_a),
    .o_pend    (w_pend_a),
    .o_ovr     (overrun_a)
`ifdef FILTRO_OVERRUN_CNT_EN
    ,
    .o_ovr_cnt (ovr_cnt_a)
`endif
  );

  filtro_canal_captura #(.ANCHO(ANCHO)) u_cap_b (
    .clk       (clk),
    .reset     (reset),
    .i_tick    (rx_done_tick_b),
    .i_uk      (uk_b),
    .i_clr     (w_clr_b),
    .o_buf     (w_buf_b),
    .o_pend    (w_pend_b),
    .o_ovr     (overrun_b)
`ifdef FILTRO_OVERRUN_CNT_EN
    ,
    .o_ovr_cnt (ovr_cnt_b)
`endif
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_pick = r_ch_sel;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pend_a | w_pend_b) begin
          w_load = 1'b1;
          w_next = ST_LOAD;
          // r_prio only arbitrates when both channels wait.
          if (w_pend_a & w_pend_b) w_pick = r_prio;
          else                     w_pick = w_pend_b;
        end
      end
      ST_LOAD:  w_next = ST_MAC;
      ST_MAC: begin
        if (r_tap == TAP_LAST) w_next = ST_SHIFT;
      end
      ST_SHIFT: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up
  // exactly with the state they belong to, yet come from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mac_uk  <= '0;
      r_ch_sel  <= 1'b0;
      r_tap     <= '0;
      r_acc_clr <= 1'b0;
      r_acc_en  <= 1'b0;
      r_hist    <= 1'b0;
      r_listo   <= 1'b0;
      r_ch_done <= 1'b0;
      r_prio    <= 1'b0;
    end else begin
      r_acc_clr <= (w_next == ST_LOAD);
      r_acc_en  <= (w_next == ST_MAC);
      r_hist    <= (w_next == ST_SHIFT);
      r_listo   <= (w_next == ST_DONE);
      r_ch_done <= (w_next == ST_DONE) & r_ch_sel;
      if (r_state == ST_MAC && w_next == ST_MAC)
        r_tap <= r_tap + 3'd1;
      else
        r_tap <= '0;
      if (w_load) begin
        r_ch_sel <= w_pick;
        r_mac_uk <= w_pick ? w_buf_b : w_buf_a;
      end
      if (r_state == ST_DONE) r_prio <= ~r_ch_sel;
    end
  end

  assign mac_uk     = r_mac_uk;
  assign ch_sel     = r_ch_sel;
  assign tap_sel    = r_tap;
  assign acc_clr    = r_acc_clr;
  assign acc_en     = r_acc_en;
  assign hist_shift = r_hist;
  assign listo      = r_listo;
  assign ch_done    = r_ch_done;

endmodule

// File: doc/filtro_scheduler.md
FILTRO_SCHEDULER -- requirements
Module: filtro_scheduler

Interface
REQ-001 Parameter ANCHO, default `ancho (12), SHALL set the sample width.
REQ-002 Parameter N_TAPS, default 5, range 1..7, SHALL set the MAC steps per output sample.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 rx_done_tick_a / rx_done_tick_b  input  1  SHALL be one-cycle sample-valid strobes for channels A and B.
REQ-006 uk_a / uk_b  input  ANCHO  SHALL carry channel samples, valid only while the matching tick is high.
REQ-007 mac_uk  output  ANCHO  SHALL carry the sample being filtered to the shared filter datapath.
REQ-008 ch_sel  output  1  SHALL select the coefficient/history bank (0=A, 1=B).
REQ-009 tap_sel  output  3  SHALL carry the tap index for the current MAC step.
REQ-010 acc_clr, acc_en, hist_shift  output  1 each  SHALL be the accumulator-clear, accumulate and history-shift strobes.
REQ-011 listo  output  1  SHALL pulse one cycle when a result is complete; ch_done  output  1 SHALL give that result's channel.
REQ-012 overrun_a / overrun_b  output  1  SHALL be sticky per-channel overrun flags.

Function
REQ-013 A tick SHALL latch its sample into that channel's buffer and set the channel's pending bit on the same edge.
REQ-014 FSM states SHALL be IDLE, LOAD, MAC, SHIFT and DONE.
REQ-015 IDLE: if any pending bit is set, the FSM SHALL pick a channel round-robin, latch ch_sel and mac_uk, and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-016 LOAD: acc_clr=1 for one cycle, then go to MAC.
REQ-017 MAC: acc_en=1 for exactly N_TAPS cycles, with tap_sel counting 0..N_TAPS-1, then go to SHIFT.
REQ-018 SHIFT: hist_shift=1 for one cycle, then go to DONE.
REQ-019 DONE: listo=1 and ch_done=ch_sel; clear the served pending bit, move round-robin priority to the other channel, then go to IDLE.
REQ-020 Latency: a tick in cycle 0 with the FSM idle SHALL give listo in cycle N_TAPS+4 (cycle 9 by default).
REQ-021 Round-robin priority after reset SHALL be channel A.
REQ-022 Simultaneous ticks on A and B SHALL set both pending bits; both SHALL be served back to back.
REQ-023 A tick on a channel whose pending bit is already set SHALL overwrite the buffer with the newer sample and set that channel's overrun flag.
REQ-024 A tick in the same cycle as DONE clears that channel SHALL leave pending set, with no overrun.
REQ-025 mac_uk and ch_sel SHALL stay stable from LOAD through DONE; a tick during that time SHALL change only the buffer.
REQ-026 Outputs acc_clr, acc_en, hist_shift and listo SHALL be mutually exclusive and registered.

Reset
REQ-027 reset low SHALL immediately force state IDLE, all outputs 0, pending bits 0, buffers 0, overrun flags 0 and priority A, including in the middle of an operation.
REQ-028 Strobes SHALL not assert before the first rising edge after reset is released.

Configuration
REQ-029 With FILTRO_OVERRUN_CNT_EN defined, the block SHALL add outputs ovr_cnt_a / ovr_cnt_b (8 bits each), counting overrun events and saturating at 255.
REQ-030 Without FILTRO_OVERRUN_CNT_EN, those ports and counters SHALL not exist; the sticky flags SHALL remain.

Structure
REQ-031 The shared constants header SHALL hold ancho, the FSM state encodings and the default N_TAPS.
REQ-032 Per-channel capture (buffer, pending, overrun, optional counter) SHALL be one sub-module, filtro_canal_captura, instantiated twice.

Verification
REQ-033 Single tick_a with uk_a=0x123, FSM idle -> mac_uk=0x123, ch_sel=0, acc_clr in cycle 2, acc_en in cycles 3-7 with tap_sel 0..4, hist_shift in cycle 8, listo with ch_done=0 in cycle 9.
REQ-034 tick_a and tick_b in the same cycle -> A served first (listo in cycle 9), B second (listo in cycle 18 with ch_done=1).
REQ-035 Two tick_b pulses (0x010 then 0x020) before service -> overrun_b=1 and mac_uk=0x020; with the macro defined, ovr_cnt_b=1.
REQ-036 reset driven low during MAC at tap 2 -> all outputs 0 immediately; after release, no listo without a new tick.
REQ-037 Continuous alternating ticks every 9 cycles -> strict A/B alternation with no overrun; 300 forced overruns -> ovr_cnt saturates at 255.
